// File: rtl/tcp_misc_pkg.sv
// tcp_misc_pkg: shared flag command encoding, flag indices and per-flag update helper
package tcp_misc_pkg;
    typedef enum logic [1:0] {NOP = 2'b00, SET = 2'b01, CLR = 2'b10} flag_cmd_e;
    localparam int RT_FLAG_IDX = 0;
    localparam int ACK_FLAG_IDX = 1;
    localparam int DATA_FLAG_IDX = 2;
    localparam int SCHED_NUM_FLAGS = 3;
    typedef logic [SCHED_NUM_FLAGS-1:0][1:0] sched_flag_cmd_t;
    typedef enum logic {SEARCH, OUTPUT} sched_state_e;
    // 2'b11 falls through as a nop
    function automatic logic apply_flag_cmd(logic cur, logic [1:0] cmd);
        return cmd == SET ? 1'b1 : cmd == CLR ? 1'b0 : cur;
    endfunction
endpackage

// File: rtl/multi_src_rr_sched_if.sv
// multi_src_rr_sched_if: update, flow lifecycle and issue signals of the scheduler
interface multi_src_rr_sched_if #(
    parameter int NUM_SRCS = 3,
    parameter int FLOWID_W = 6,
    parameter int NUM_FLAGS = 3,
    parameter int DROP_CNT_W = 16
);
    logic [NUM_SRCS-1:0] src_upd_val;
    logic [NUM_SRCS*FLOWID_W-1:0] src_upd_flowid;
    logic [NUM_SRCS*2*NUM_FLAGS-1:0] src_upd_cmd;
    logic [NUM_SRCS-1:0] src_upd_rdy;
    logic new_flow_val;
    logic [FLOWID_W-1:0] new_flow_flowid;
    logic retire_val;
    logic [FLOWID_W-1:0] retire_flowid;
    logic sched_req_val;
    logic [FLOWID_W-1:0] sched_req_flowid;
    logic [NUM_FLAGS-1:0] sched_req_flags;
    logic sched_req_rdy;
    logic [DROP_CNT_W-1:0] drop_cnt;
    modport master (
        output src_upd_val, src_upd_flowid, src_upd_cmd, new_flow_val, new_flow_flowid,
               retire_val, retire_flowid, sched_req_rdy,
        input  src_upd_rdy, sched_req_val, sched_req_flowid, sched_req_flags, drop_cnt
    );
    modport slave (
        input  src_upd_val, src_upd_flowid, src_upd_cmd, new_flow_val, new_flow_flowid,
               retire_val, retire_flowid, sched_req_rdy,
        output src_upd_rdy, sched_req_val, sched_req_flowid, sched_req_flags, drop_cnt
    );
endinterface

// File: rtl/rr_find_first_wrap.sv
// rr_find_first_wrap: circular priority encoder, first set bit at or after ptr, wrapping
module rr_find_first_wrap #(
    parameter int WIDTH = 4,
    parameter int PTR_W = 2
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [PTR_W-1:0] ptr,
    output logic found,
    output logic [PTR_W-1:0] idx
);
    logic [WIDTH-1:0] upper;
    logic hi_found;
    logic [PTR_W-1:0] hi_idx, lo_idx;
    // downward scan so the lowest index of each pass wins
    always_comb begin
        upper = '0;
        hi_found = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            upper[i] = vec[i] && i >= int'(ptr);
            if (upper[i]) begin
                hi_found = 1'b1;
                hi_idx = PTR_W'(i);
            end
            if (vec[i]) lo_idx = PTR_W'(i);
        end
    end
    assign found = |vec;
    assign idx = hi_found ? hi_idx : lo_idx;
endmodule

// File: rtl/multi_src_rr_sched.sv
// multi_src_rr_sched: round-robin flow scheduler fed by per-flow flag updates from several sources
module multi_src_rr_sched
    import tcp_misc_pkg::*;
#(
    parameter int NUM_SRCS = 3,
    parameter int FLOWID_W = 6,
    parameter int NUM_FLAGS = 3,
    parameter int DROP_CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    multi_src_rr_sched_if.slave bus
);
    localparam int NUM_FLOWS = 2 ** FLOWID_W;
    localparam int SRC_W = NUM_SRCS > 1 ? $clog2(NUM_SRCS) : 1;

    logic [SRC_W-1:0] arb_ptr, gnt;
    logic any_val, acc, upd_drop;
    logic [FLOWID_W-1:0] upd_fid;
    logic [NUM_FLAGS-1:0][1:0] upd_cmd;
    logic [NUM_FLAGS-1:0] upd_base, upd_flags;
    logic [NUM_FLOWS-1:0] active, eligible;
    logic [NUM_FLAGS-1:0] flags [NUM_FLOWS];
    logic [DROP_CNT_W-1:0] drop_cnt;
    logic el_found;
    logic [FLOWID_W-1:0] el_idx, rr_ptr, req_fid;
    logic [NUM_FLAGS-1:0] req_flags;
    logic req_val;
    sched_state_e state;

    rr_find_first_wrap #(.WIDTH(NUM_SRCS), .PTR_W(SRC_W)) u_arb (
        .vec(bus.src_upd_val), .ptr(arb_ptr), .found(any_val), .idx(gnt)
    );
    rr_find_first_wrap #(.WIDTH(NUM_FLOWS), .PTR_W(FLOWID_W)) u_sel (
        .vec(eligible), .ptr(rr_ptr), .found(el_found), .idx(el_idx)
    );

    assign acc = any_val & rst_n;
    assign bus.src_upd_rdy = acc ? NUM_SRCS'(1) << gnt : '0;
    assign upd_fid = bus.src_upd_flowid[int'(gnt)*FLOWID_W +: FLOWID_W];
    assign upd_cmd = bus.src_upd_cmd[int'(gnt)*2*NUM_FLAGS +: 2*NUM_FLAGS];
    // retire wins over everything; a same-cycle new_flow rescues an update to an idle flow
    assign upd_drop = acc & ((bus.retire_val & (bus.retire_flowid == upd_fid)) |
                      (~active[upd_fid] & ~(bus.new_flow_val & (bus.new_flow_flowid == upd_fid))));

    always_comb begin
        upd_base = (bus.new_flow_val && bus.new_flow_flowid == upd_fid) ? '0 : flags[upd_fid];
        upd_flags = upd_base;
        for (int b = 0; b < NUM_FLAGS; b++) upd_flags[b] = apply_flag_cmd(upd_base[b], upd_cmd[b]);
    end

    always_comb begin
        eligible = '0;
        for (int f = 0; f < NUM_FLOWS; f++) eligible[f] = active[f] & |flags[f];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= '0;
            for (int f = 0; f < NUM_FLOWS; f++) flags[f] <= '0;
            drop_cnt <= '0;
            arb_ptr <= '0;
        end else begin
            if (acc) arb_ptr <= gnt == SRC_W'(NUM_SRCS - 1) ? '0 : gnt + 1'b1;
            if (upd_drop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
            for (int f = 0; f < NUM_FLOWS; f++) begin
                if (bus.retire_val && bus.retire_flowid == FLOWID_W'(f)) begin
                    active[f] <= 1'b0;
                    flags[f] <= '0;
                end else if (bus.new_flow_val && bus.new_flow_flowid == FLOWID_W'(f)) begin
                    active[f] <= 1'b1;
                    flags[f] <= (acc && upd_fid == FLOWID_W'(f)) ? upd_flags : '0;
                end else if (acc && active[f] && upd_fid == FLOWID_W'(f)) begin
                    flags[f] <= upd_flags;
                end
            end
        end
    end

    // a committed issue is frozen until accepted, whatever happens to the flow meanwhile
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH;
            rr_ptr <= '0;
            req_val <= 1'b0;
            req_fid <= '0;
            req_flags <= '0;
        end else if (state == SEARCH) begin
            if (el_found) begin
                state <= OUTPUT;
                req_val <= 1'b1;
                req_fid <= el_idx;
                req_flags <= flags[el_idx];
            end
        end else if (bus.sched_req_rdy) begin
            state <= SEARCH;
            req_val <= 1'b0;
            rr_ptr <= req_fid + 1'b1;
        end
    end

    assign bus.sched_req_val = req_val;
    assign bus.sched_req_flowid = req_fid;
    assign bus.sched_req_flags = req_flags;
    assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_multi_src_rr_sched.sv
// tb_multi_src_rr_sched: directed checks of issue order, arbitration, collisions and drop counting
module tb_multi_src_rr_sched;
    localparam logic [5:0] SET_RT = 6'h01, SET_ACK = 6'h04, SET_DATA = 6'h10, CLR_ACK = 6'h08;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int got;
    logic [5:0] exp_order [6] = '{6'd0, 6'd2, 6'd63, 6'd0, 6'd2, 6'd63};
    logic [2:0] exp_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    multi_src_rr_sched_if #(.NUM_SRCS(3), .FLOWID_W(6), .NUM_FLAGS(3), .DROP_CNT_W(4)) bus ();
    multi_src_rr_sched #(.NUM_SRCS(3), .FLOWID_W(6), .NUM_FLAGS(3), .DROP_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.src_upd_val = '0;
        bus.src_upd_flowid = '0;
        bus.src_upd_cmd = '0;
        bus.new_flow_val = 1'b0;
        bus.new_flow_flowid = '0;
        bus.retire_val = 1'b0;
        bus.retire_flowid = '0;
    endtask

    task automatic upd(input int s, input logic [5:0] fid, input logic [5:0] cmd);
        bus.src_upd_val[s] = 1'b1;
        bus.src_upd_flowid[s*6 +: 6] = fid;
        bus.src_upd_cmd[s*6 +: 6] = cmd;
    endtask

    task automatic new_flow(input logic [5:0] fid);
        bus.new_flow_val = 1'b1;
        bus.new_flow_flowid = fid;
    endtask

    task automatic do_reset();
        idle();
        bus.sched_req_rdy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        bus.sched_req_rdy = 1'b0;
        bus.src_upd_val = 3'b111;
        repeat (2) @(negedge clk);
        chk("rst_val", bus.sched_req_val, 0);
        chk("rst_fid", bus.sched_req_flowid, 0);
        chk("rst_flags", bus.sched_req_flags, 0);
        chk("rst_drop", bus.drop_cnt, 0);
        chk("rst_rdy", bus.src_upd_rdy, 0);
        idle();
        rst_n = 1'b1;

        @(negedge clk) new_flow(6'd3);
        @(negedge clk) idle();
        upd(1, 6'd3, SET_ACK);
        #1 chk("basic_rdy", bus.src_upd_rdy, 3'b010);
        @(negedge clk) idle();
        chk("basic_lat", bus.sched_req_val, 0);
        @(negedge clk) chk("basic_val", bus.sched_req_val, 1);
        chk("basic_fid", bus.sched_req_flowid, 3);
        chk("basic_flags", bus.sched_req_flags, 3'b010);
        @(negedge clk) chk("basic_hold", bus.sched_req_flowid, 3);
        chk("basic_hold_val", bus.sched_req_val, 1);
        bus.sched_req_rdy = 1'b1;
        @(negedge clk) chk("basic_drop_val", bus.sched_req_val, 0);
        bus.sched_req_rdy = 1'b0;
        @(negedge clk) chk("reissue_val", bus.sched_req_val, 1);
        chk("reissue_fid", bus.sched_req_flowid, 3);
        bus.sched_req_rdy = 1'b1;
        upd(0, 6'd3, CLR_ACK);
        @(negedge clk) idle();
        bus.sched_req_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("cleared_idle%0d", i), bus.sched_req_val, 0);
            @(negedge clk);
        end

        new_flow(6'd5);
        upd(0, 6'd5, SET_DATA);
        @(negedge clk) idle();
        @(negedge clk) chk("f5_val", bus.sched_req_val, 1);
        chk("f5_fid", bus.sched_req_flowid, 5);
        chk("f5_flags", bus.sched_req_flags, 3'b100);
        #2 rst_n = 1'b0;
        #1 chk("async_val", bus.sched_req_val, 0);
        chk("async_fid", bus.sched_req_flowid, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) chk($sformatf("post_rst_idle%0d", i), bus.sched_req_val, 0);
        end
        chk("post_rst_drop", bus.drop_cnt, 0);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            new_flow(i == 0 ? 6'd0 : i == 1 ? 6'd2 : 6'd63);
            upd(0, i == 0 ? 6'd0 : i == 1 ? 6'd2 : 6'd63, SET_DATA);
            @(negedge clk);
        end
        idle();
        bus.sched_req_rdy = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (bus.sched_req_val) begin
                chk($sformatf("order%0d", got), bus.sched_req_flowid, exp_order[got]);
                got++;
            end
            @(negedge clk);
        end
        chk("order_cnt", got, 6);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            new_flow(6'(10 + i));
            @(negedge clk);
        end
        idle();
        for (int i = 0; i < 6; i++) begin
            upd(0, 6'd10, SET_RT);
            upd(1, 6'd11, SET_ACK);
            upd(2, 6'd12, SET_DATA);
            #1 chk($sformatf("arb%0d", i), bus.src_upd_rdy, exp_rdy[i]);
            @(negedge clk);
        end
        idle();
        chk("arb_iss0_fid", bus.sched_req_flowid, 10);
        chk("arb_iss0_flags", bus.sched_req_flags, 3'b001);
        bus.sched_req_rdy = 1'b1;
        @(negedge clk) chk("arb_gap0", bus.sched_req_val, 0);
        @(negedge clk) chk("arb_iss1_fid", bus.sched_req_flowid, 11);
        chk("arb_iss1_flags", bus.sched_req_flags, 3'b010);
        @(negedge clk) chk("arb_gap1", bus.sched_req_val, 0);
        @(negedge clk) chk("arb_iss2_fid", bus.sched_req_flowid, 12);
        chk("arb_iss2_flags", bus.sched_req_flags, 3'b100);
        bus.sched_req_rdy = 1'b0;
        chk("arb_drop", bus.drop_cnt, 0);

        do_reset();
        new_flow(6'd7);
        @(negedge clk);
        bus.retire_val = 1'b1;
        bus.retire_flowid = 6'd7;
        upd(0, 6'd7, SET_RT);
        @(negedge clk) idle();
        chk("coll_drop", bus.drop_cnt, 1);
        chk("coll_val0", bus.sched_req_val, 0);
        @(negedge clk) chk("coll_val1", bus.sched_req_val, 0);
        new_flow(6'd9);
        upd(0, 6'd9, SET_DATA);
        @(negedge clk) idle();
        @(negedge clk) chk("nf9_val", bus.sched_req_val, 1);
        chk("nf9_fid", bus.sched_req_flowid, 9);
        chk("nf9_flags", bus.sched_req_flags, 3'b100);
        chk("nf9_drop", bus.drop_cnt, 1);
        upd(0, 6'd7, SET_RT);
        @(negedge clk) idle();
        chk("f7_inactive_drop", bus.drop_cnt, 2);
        chk("nf9_hold", bus.sched_req_flowid, 9);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            upd(0, 6'd1, SET_DATA);
            @(negedge clk);
        end
        idle();
        chk("drop_sat", bus.drop_cnt, 15);
        chk("drop_no_issue", bus.sched_req_val, 0);
        @(negedge clk) chk("drop_no_issue2", bus.sched_req_val, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
